// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - FPU-facing types, scheduler state and accelerator-to-FPU request mapping
package acc_pkg;

  typedef logic [31:0] data_t;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } fpu_op_e;

  typedef enum logic [2:0] {
    RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4, DYN = 3'd7
  } roundmode_e;

  typedef enum logic [2:0] {
    FP32 = 3'd0, FP64 = 3'd1, FP16 = 3'd2, FP8 = 3'd3, FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {INT8, INT16, INT32, INT64} int_format_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  typedef enum logic [1:0] {
    ACC_NATIVE = 2'd0, ACC_SET_W = 2'd1, ACC_PREPIV = 2'd2, ACC_PIV = 2'd3
  } acc_op_e;

  typedef struct packed {
    acc_op_e     acc_op;
    fpu_op_e     fpu_operation;
    logic        op_mod_i;
    logic [4:0]  rd;
    data_t       op0;
    data_t       op1;
    data_t       op2;
  } acc_instr_t;

  typedef struct packed {
    data_t [2:0] operands;
    roundmode_e  rnd_mode;
    fpu_op_e     op;
    logic        op_mod;
    fp_format_e  src_fmt;
    fp_format_e  dst_fmt;
    int_format_e int_fmt;
    logic        vectorial_op;
    logic        simd_mask;
    logic [31:0] tag;
  } fpu_req_t;

  typedef struct packed {
    data_t       result;
    status_t     status;
    logic [31:0] tag;
  } fpu_resp_t;

  typedef enum logic {IDLE, ISSUE} sched_state_e;

  localparam roundmode_e  ACC_RND_MODE = RNE;
  localparam fp_format_e  ACC_FP_FMT   = FP32;
  localparam int_format_e ACC_INT_FMT  = INT32;

  // PIV computes op0 - op1*W as FNMSUB(a=op1, b=W, c=op0); the tag carries rd back.
  function automatic fpu_req_t acc_to_fpu_req(input acc_instr_t instr, input data_t w);
    fpu_req_t req;
    req              = '0;
    req.rnd_mode     = ACC_RND_MODE;
    req.src_fmt      = ACC_FP_FMT;
    req.dst_fmt      = ACC_FP_FMT;
    req.int_fmt      = ACC_INT_FMT;
    req.vectorial_op = 1'b0;
    req.simd_mask    = 1'b1;
    req.tag          = {27'b0, instr.rd};
    case (instr.acc_op)
      ACC_PREPIV: begin
        req.op          = DIV;
        req.op_mod      = 1'b0;
        req.operands[0] = instr.op0;
        req.operands[1] = instr.op1;
        req.operands[2] = '0;
      end
      ACC_PIV: begin
        req.op          = FNMSUB;
        req.op_mod      = 1'b0;
        req.operands[0] = instr.op1;
        req.operands[1] = w;
        req.operands[2] = instr.op0;
      end
      default: begin
        req.op          = instr.fpu_operation;
        req.op_mod      = instr.op_mod_i;
        req.operands[0] = instr.op0;
        req.operands[1] = instr.op1;
        req.operands[2] = instr.op2;
      end
    endcase
    return req;
  endfunction

endpackage

// File: rtl/acc_outstanding_cnt.sv
// rtl/acc_outstanding_cnt.sv - saturating up/down counter of in-flight FPU requests
module acc_outstanding_cnt #(
  parameter int unsigned MAX = 4,
  parameter int unsigned CW  = $clog2(MAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A decrement at zero comes from a response that outlived a reset; hold at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + ONE_C;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE_C;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == MAX_C);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/acc_fpu_scheduler.sv
// rtl/acc_fpu_scheduler.sv - issues accelerator/native instructions to one FPU; optional ACC_SCHED_STICKY_FFLAGS_EN
module acc_fpu_scheduler
  import acc_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       instr_valid_i,
  output logic       instr_ready_o,
  input  acc_instr_t instr_i,
  output logic       fpu_req_valid_o,
  input  logic       fpu_req_ready_i,
  output fpu_req_t   fpu_req_o,
  input  logic       fpu_resp_valid_i,
  output logic       fpu_resp_ready_o,
  input  fpu_resp_t  fpu_resp_i,
  output logic       wb_valid_o,
  input  logic       wb_ready_i,
  output logic [4:0] wb_rd_o,
  output data_t      wb_data_o,
  output status_t    wb_status_o,
  output logic       busy_o,
  output logic [4:0] fflags_o,
  input  logic       fflags_clr_i
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  sched_state_e  state_q, state_d;
  fpu_req_t      req_q, req_d;
  data_t         w_q, w_d;
  logic [CW-1:0] cnt;
  logic          cnt_full, cnt_empty;
  logic          instr_hs, req_hs, wb_hs;

  assign instr_ready_o   = (state_q == IDLE) && !cnt_full;
  assign fpu_req_valid_o = (state_q == ISSUE);
  assign instr_hs        = instr_valid_i && instr_ready_o;
  assign req_hs          = fpu_req_valid_o && fpu_req_ready_i;
  assign wb_hs           = fpu_resp_valid_i && wb_ready_i;

  // W is captured into the request at accept time, so later SET_W cannot disturb it.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    w_d     = w_q;
    case (state_q)
      IDLE: begin
        if (instr_hs) begin
          if (instr_i.acc_op == ACC_SET_W) begin
            w_d = instr_i.op0;
          end else begin
            req_d   = acc_to_fpu_req(instr_i, w_q);
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (fpu_req_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      w_q     <= w_d;
    end
  end

  acc_outstanding_cnt #(
    .MAX (MAX_OUTSTANDING),
    .CW  (CW)
  ) u_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (req_hs),
    .dec_i   (wb_hs),
    .cnt_o   (cnt),
    .full_o  (cnt_full),
    .empty_o (cnt_empty)
  );

  assign fpu_req_o        = req_q;
  assign wb_valid_o       = fpu_resp_valid_i;
  assign fpu_resp_ready_o = wb_ready_i;
  assign wb_rd_o          = fpu_resp_i.tag[4:0];
  assign wb_data_o        = fpu_resp_i.result;
  assign wb_status_o      = fpu_resp_i.status;
  assign busy_o           = (state_q == ISSUE) || !cnt_empty;

  logic [26:0]   unused_tag_hi;
  logic [CW-1:0] unused_cnt;
  assign unused_tag_hi = fpu_resp_i.tag[31:5];
  assign unused_cnt    = cnt;

`ifdef ACC_SCHED_STICKY_FFLAGS_EN
  logic [4:0] fflags_q, fflags_d;

  always_comb begin
    fflags_d = fflags_q;
    if (fflags_clr_i) begin
      fflags_d = '0;
    end else if (wb_hs) begin
      fflags_d = fflags_q | fpu_resp_i.status;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign fflags_o = fflags_q;
`else
  logic unused_fflags_clr;
  assign unused_fflags_clr = fflags_clr_i;
  assign fflags_o          = '0;
`endif

endmodule

// File: tb/tb_acc_fpu_scheduler.sv
// tb/tb_acc_fpu_scheduler.sv - directed scoreboard bench for acc_fpu_scheduler with MAX_OUTSTANDING=2
module tb_acc_fpu_scheduler;
  import acc_pkg::*;

  localparam int unsigned MAXO = 2;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       instr_valid_i;
  logic       instr_ready_o;
  acc_instr_t instr_i;
  logic       fpu_req_valid_o;
  logic       fpu_req_ready_i;
  fpu_req_t   fpu_req_o;
  logic       fpu_resp_valid_i;
  logic       fpu_resp_ready_o;
  fpu_resp_t  fpu_resp_i;
  logic       wb_valid_o;
  logic       wb_ready_i;
  logic [4:0] wb_rd_o;
  data_t      wb_data_o;
  status_t    wb_status_o;
  logic       busy_o;
  logic [4:0] fflags_o;
  logic       fflags_clr_i;

  always #5 clk_i = ~clk_i;

  acc_fpu_scheduler #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .instr_valid_i    (instr_valid_i),
    .instr_ready_o    (instr_ready_o),
    .instr_i          (instr_i),
    .fpu_req_valid_o  (fpu_req_valid_o),
    .fpu_req_ready_i  (fpu_req_ready_i),
    .fpu_req_o        (fpu_req_o),
    .fpu_resp_valid_i (fpu_resp_valid_i),
    .fpu_resp_ready_o (fpu_resp_ready_o),
    .fpu_resp_i       (fpu_resp_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wb_rd_o          (wb_rd_o),
    .wb_data_o        (wb_data_o),
    .wb_status_o      (wb_status_o),
    .busy_o           (busy_o),
    .fflags_o         (fflags_o),
    .fflags_clr_i     (fflags_clr_i)
  );

  int checks = 0;
  int errors = 0;

  fpu_req_t exp_req_q[$];
  data_t    exp_data[32];
  status_t  exp_status[32];
  fpu_req_t e;

  task automatic chk(input string name, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s", name);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic acc_instr_t mk_instr(input acc_op_e aop, input fpu_op_e fop,
                                          input logic mod, input logic [4:0] rd,
                                          input data_t a, input data_t b, input data_t c);
    acc_instr_t in;
    in.acc_op        = aop;
    in.fpu_operation = fop;
    in.op_mod_i      = mod;
    in.rd            = rd;
    in.op0           = a;
    in.op1           = b;
    in.op2           = c;
    return in;
  endfunction

  function automatic fpu_req_t mk_req(input fpu_op_e op, input logic mod,
                                      input data_t a, input data_t b, input data_t c,
                                      input logic [4:0] rd);
    fpu_req_t r;
    r.operands[0]  = a;
    r.operands[1]  = b;
    r.operands[2]  = c;
    r.rnd_mode     = RNE;
    r.op           = op;
    r.op_mod       = mod;
    r.src_fmt      = FP32;
    r.dst_fmt      = FP32;
    r.int_fmt      = INT32;
    r.vectorial_op = 1'b0;
    r.simd_mask    = 1'b1;
    r.tag          = {27'b0, rd};
    return r;
  endfunction

  task automatic send(input acc_instr_t in);
    int n = 0;
    instr_i       = in;
    instr_valid_i = 1'b1;
    while (!instr_ready_o && n < 20) begin
      tick();
      n++;
    end
    chk("accept_in_time", instr_ready_o === 1'b1);
    tick();
    instr_valid_i = 1'b0;
  endtask

  task automatic fpu_take(input int stall);
    fpu_req_t x;
    int n = 0;
    while (!fpu_req_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("req_valid", fpu_req_valid_o === 1'b1);
    x = exp_req_q.pop_front();
    chk("req_fields", fpu_req_o === x);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("req_stable", fpu_req_o === x);
      chk("stall_valid", fpu_req_valid_o === 1'b1);
      chk("stall_instr_ready", instr_ready_o === 1'b0);
    end
    fpu_req_ready_i = 1'b1;
    tick();
    fpu_req_ready_i = 1'b0;
  endtask

  task automatic respond(input logic [4:0] rd, input int hold);
    fpu_resp_i.result = exp_data[rd];
    fpu_resp_i.status = exp_status[rd];
    fpu_resp_i.tag    = {27'b0, rd};
    fpu_resp_valid_i  = 1'b1;
    wb_ready_i        = (hold == 0);
    #1;
    chk("wb_valid", wb_valid_o === 1'b1);
    chk("wb_rd", wb_rd_o === rd);
    chk("wb_data", wb_data_o === exp_data[rd]);
    chk("wb_status", wb_status_o === exp_status[rd]);
    for (int i = 0; i < hold; i++) begin
      chk("resp_backpressure", fpu_resp_ready_o === 1'b0);
      tick();
    end
    wb_ready_i = 1'b1;
    #1;
    chk("resp_ready", fpu_resp_ready_o === 1'b1);
    tick();
    fpu_resp_valid_i = 1'b0;
    wb_ready_i       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      exp_status[i] = '0;
      exp_data[i]   = '0;
    end
    rst_i = 1'b1;
    instr_valid_i = 1'b0;
    instr_i = '0;
    fpu_req_ready_i = 1'b0;
    fpu_resp_valid_i = 1'b0;
    fpu_resp_i = '0;
    wb_ready_i = 1'b0;
    fflags_clr_i = 1'b0;
    tick();
    tick();
    chk("rst_req_valid", fpu_req_valid_o === 1'b0);
    chk("rst_busy", busy_o === 1'b0);
    chk("rst_fflags", fflags_o === 5'b0);
    chk("rst_req_reg", fpu_req_o === fpu_req_t'('0));
    rst_i = 1'b0;
    tick();
    chk("idle_ready", instr_ready_o === 1'b1);

    // SET_W then PIV: 10 - 3*2 = 4
    send(mk_instr(ACC_SET_W, FMADD, 1'b0, 5'd0, 32'h40000000, 32'h0, 32'h0));
    chk("setw_no_req", fpu_req_valid_o === 1'b0);
    chk("setw_not_busy", busy_o === 1'b0);
    chk("setw_ready_again", instr_ready_o === 1'b1);
    exp_req_q.push_back(mk_req(FNMSUB, 1'b0, 32'h40400000, 32'h40000000, 32'h41200000, 5'd7));
    exp_data[7] = 32'h40800000;
    send(mk_instr(ACC_PIV, ADD, 1'b1, 5'd7, 32'h41200000, 32'h40400000, 32'hDEADBEEF));
    chk("issue_latency", fpu_req_valid_o === 1'b1);
    fpu_take(0);
    chk("busy_outstanding", busy_o === 1'b1);
    respond(5'd7, 0);
    chk("busy_drained", busy_o === 1'b0);

    // PREPIV 10/2 = 5 with FPU stalled for 5 cycles
    exp_req_q.push_back(mk_req(DIV, 1'b0, 32'h41200000, 32'h40000000, 32'h0, 5'd3));
    exp_data[3] = 32'h40A00000;
    send(mk_instr(ACC_PREPIV, FMADD, 1'b1, 5'd3, 32'h41200000, 32'h40000000, 32'h12345678));
    fpu_take(5);
    respond(5'd3, 0);

    // Fill both outstanding slots with native ops
    exp_req_q.push_back(mk_req(ADD, 1'b0, 32'h3F800000, 32'h40000000, 32'h0, 5'd2));
    exp_data[2] = 32'h40400000;
    send(mk_instr(ACC_NATIVE, ADD, 1'b0, 5'd2, 32'h3F800000, 32'h40000000, 32'h0));
    fpu_take(0);
    exp_req_q.push_back(mk_req(MUL, 1'b1, 32'h40000000, 32'h40400000, 32'h3F000000, 5'd5));
    exp_data[5] = 32'h40C00000;
    send(mk_instr(ACC_NATIVE, MUL, 1'b1, 5'd5, 32'h40000000, 32'h40400000, 32'h3F000000));
    fpu_take(0);

    exp_req_q.push_back(mk_req(ADD, 1'b0, 32'h40800000, 32'h40800000, 32'h0, 5'd4));
    exp_data[4] = 32'h41000000;
    instr_i       = mk_instr(ACC_NATIVE, ADD, 1'b0, 5'd4, 32'h40800000, 32'h40800000, 32'h0);
    instr_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("full_blocks", instr_ready_o === 1'b0);
      chk("full_no_req", fpu_req_valid_o === 1'b0);
      tick();
    end
    respond(5'd5, 2);
    chk("resume_after_wb", instr_ready_o === 1'b1);
    tick();
    instr_valid_i = 1'b0;
    chk("third_issued", fpu_req_valid_o === 1'b1);

    // Request and writeback handshake in the same cycle
    e = exp_req_q.pop_front();
    chk("simul_req", fpu_req_o === e);
    fpu_req_ready_i   = 1'b1;
    fpu_resp_i.result = exp_data[2];
    fpu_resp_i.status = exp_status[2];
    fpu_resp_i.tag    = 32'd2;
    fpu_resp_valid_i  = 1'b1;
    wb_ready_i        = 1'b1;
    #1;
    chk("simul_wb_rd", wb_rd_o === 5'd2);
    chk("simul_wb_data", wb_data_o === exp_data[2]);
    tick();
    fpu_req_ready_i  = 1'b0;
    fpu_resp_valid_i = 1'b0;
    wb_ready_i       = 1'b0;
    chk("simul_one_left_ready", instr_ready_o === 1'b1);

    exp_req_q.push_back(mk_req(SQRT, 1'b0, 32'h41800000, 32'h0, 32'h0, 5'd6));
    exp_data[6] = 32'h40800000;
    send(mk_instr(ACC_NATIVE, SQRT, 1'b0, 5'd6, 32'h41800000, 32'h0, 32'h0));
    fpu_take(0);
    instr_i       = mk_instr(ACC_NATIVE, ADD, 1'b0, 5'd8, 32'h0, 32'h0, 32'h0);
    instr_valid_i = 1'b1;
    #1;
    chk("simul_cnt_full", instr_ready_o === 1'b0);
    instr_valid_i = 1'b0;
    respond(5'd4, 0);
    respond(5'd6, 0);
    chk("all_drained", busy_o === 1'b0);

    // Reset while a request is pending
    send(mk_instr(ACC_NATIVE, ADD, 1'b0, 5'd10, 32'h3F800000, 32'h3F800000, 32'h0));
    chk("pre_reset_valid", fpu_req_valid_o === 1'b1);
    rst_i = 1'b1;
    #1;
    chk("async_rst_valid", fpu_req_valid_o === 1'b0);
    chk("async_rst_busy", busy_o === 1'b0);
    tick();
    rst_i = 1'b0;
    tick();
    exp_data[10] = 32'h40000000;
    respond(5'd10, 0);
    chk("cnt_saturate", busy_o === 1'b0);
    chk("post_rst_ready", instr_ready_o === 1'b1);

    // W was cleared by reset: 10 - 3*0 = 10
    exp_req_q.push_back(mk_req(FNMSUB, 1'b0, 32'h40400000, 32'h0, 32'h41200000, 5'd12));
    exp_data[12] = 32'h41200000;
    send(mk_instr(ACC_PIV, FMADD, 1'b0, 5'd12, 32'h41200000, 32'h40400000, 32'h0));
    fpu_take(0);
    respond(5'd12, 0);

    // Divide by zero reports DZ
    exp_req_q.push_back(mk_req(DIV, 1'b0, 32'h3F800000, 32'h0, 32'h0, 5'd11));
    exp_data[11]   = 32'h7F800000;
    exp_status[11] = 5'b01000;
    send(mk_instr(ACC_PREPIV, FMADD, 1'b0, 5'd11, 32'h3F800000, 32'h0, 32'h0));
    fpu_take(0);
    respond(5'd11, 0);
`ifdef ACC_SCHED_STICKY_FFLAGS_EN
    chk("fflags_dz_set", fflags_o === 5'b01000);
`else
    chk("fflags_tied_off", fflags_o === 5'b00000);
`endif
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    chk("fflags_cleared", fflags_o === 5'b00000);
    chk("scoreboard_empty", exp_req_q.size() === 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_fpu_scheduler.md
# acc_fpu_scheduler

Sequences accelerator instructions (`acc_instr_t`) onto a single FPnew FPU instance and returns results to the register file. Native FPU operations are forwarded unchanged. Accelerator operations are expanded into FPU requests:
- PREPIV becomes a divide.
- PIV becomes a fused multiply-subtract against an internal pivot weight register W.
- SET_W loads W locally.

The block tracks outstanding FPU requests, bounds them to a compile-time limit, and routes tagged responses to a writeback port.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum FPU requests issued but not yet written back; range 1..16.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `instr_valid_i`  in  1  instruction offered.
- `instr_ready_o`  out  1  instruction accepted when high together with valid.
- `instr_i`  in  `acc_instr_t`  instruction.
- `fpu_req_valid_o`  out  1  FPU request valid.
- `fpu_req_ready_i`  in  1  FPU accepts request.
- `fpu_req_o`  out  `fpu_req_t`  FPU request.
- `fpu_resp_valid_i`  in  1  FPU result valid.
- `fpu_resp_ready_o`  out  1  result consumed.
- `fpu_resp_i`  in  `fpu_resp_t`  result, status and tag.
- `wb_valid_o`  out  1  writeback valid.
- `wb_ready_i`  in  1  register file accepts the writeback.
- `wb_rd_o`  out  5  destination register.
- `wb_data_o`  out  32  result.
- `wb_status_o`  out  `status_t`  FPU flags of this result.
- `busy_o`  out  1  high when the FSM is in ISSUE or the outstanding count is nonzero.
- `fflags_o`  out  5  sticky flags; see Configuration.
- `fflags_clr_i`  in  1  clears sticky flags.

Decided: one clock `clk_i`; reset `rst_i` is asynchronous and active-high.

## Operation
- FSM states are IDLE and ISSUE. Reset state is IDLE.
- `instr_ready_o` = (state==IDLE) && (cnt < MAX_OUTSTANDING).
- Accepted instruction in IDLE:
  - SET_W (`acc_op`=1): w_q <= op0 at the next edge. FSM stays in IDLE. No FPU request, no writeback.
  - Any other instruction: the request register is loaded and the FSM goes to ISSUE.
- ISSUE holds `fpu_req_valid_o`=1 with stable `fpu_req_o` until `fpu_req_ready_i`, then returns to IDLE.
- Request mapping:
  - Native (`acc_op`=0): op = `fpu_operation`, op_mod = `op_mod_i`, operands {op0, op1, op2}.
  - PREPIV: op = DIV, operands {op0, op1, 0}; result is op0/op1.
  - PIV: op = FNMSUB, op_mod 0, operands {op1, w_q, op0}; result is op0 − op1·W. W is sampled at instruction accept, not at FPU handshake.
  - Common fields for every request:
    - rnd_mode RNE
    - src_fmt and dst_fmt FP32
    - int_fmt INT32
    - vectorial_op 0
    - simd_mask 1
    - tag = {27'b0, rd}
- Outstanding counter `cnt` (width $clog2(MAX_OUTSTANDING+1)):
  - +1 on FPU request handshake.
  - −1 on writeback handshake.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
  - A response arriving while cnt==0 is passed through and the counter saturates at 0.
- Response path is combinational pass-through:
  - `wb_valid_o` = `fpu_resp_valid_i`; `fpu_resp_ready_o` = `wb_ready_i`.
  - `wb_rd_o` = tag[4:0]; `wb_data_o` = result; `wb_status_o` = status.
- Responses may return in any order; rd is recovered from the tag.
- Reset values: state IDLE, cnt 0, w_q 0, request register 0, `fpu_req_valid_o` 0, `busy_o` 0, `fflags_o` 0.
- Reset mid-ISSUE drops the pending request. In-flight FPU results after reset are still passed through.

## Timing
- Instruction accepted at edge N → `fpu_req_valid_o` high from cycle N+1.
- Peak throughput is one FPU instruction every 2 cycles. Back-to-back SET_W is accepted every cycle.
- SET_W at edge N is visible to a PIV accepted at edge N+1.
- Writeback adds zero latency after the FPU response.
- Instruction acceptance is blocked while cnt==MAX_OUTSTANDING. It resumes the cycle after a writeback handshake decrements cnt.

## Configuration
- `ACC_SCHED_STICKY_FFLAGS_EN` defined: `fflags_o` ORs in `wb_status_o` on every writeback handshake. `fflags_clr_i` zeroes it the next cycle; a clear has priority over a same-cycle OR.
- Undefined: `fflags_o` is tied to 0 and `fflags_clr_i` is ignored.

## Structure
- `acc_pkg` holds:
  - the `sched_state_e` enum (IDLE, ISSUE);
  - the constants `ACC_RND_MODE` = RNE, `ACC_FP_FMT` = FP32, `ACC_INT_FMT` = INT32;
  - the function `acc_to_fpu_req(acc_instr_t, data_t w)` returning `fpu_req_t`.
- Sub-module `acc_outstanding_cnt` implements the saturating up/down counter with full and empty outputs.

## Test plan
- SET_W op0=0x40000000, then PIV op0=0x41200000, op1=0x40400000, rd=7 → FPU sees FNMSUB {0x40400000, 0x40000000, 0x41200000}; writeback rd=7, data=0x40800000.
- PREPIV op0=0x41200000, op1=0x40000000, rd=3 → DIV request; writeback rd=3, data=0x40A00000, tag=3.
- `fpu_req_ready_i` held low for 5 cycles → request stable, `instr_ready_o`=0, and the request issues on the first ready cycle.
- MAX_OUTSTANDING=2 with responses withheld → third instruction stalls until one writeback completes. Simultaneous issue and writeback keeps cnt unchanged.
- Responses returned in order rd=5 then rd=2 → `wb_rd_o` follows the tags. `wb_ready_i`=0 back-pressures `fpu_resp_ready_o`.
- `rst_i` pulsed mid-ISSUE → `fpu_req_valid_o`=0 and cnt=0 immediately. With the macro defined, a DIV-by-zero result sets `fflags_o`[3] and `fflags_clr_i` clears it.
